// File: rtl/inst_buffer_if.sv
// Packet types and the fetch/decode bundle of the instruction buffer.
`ifndef WAY_NUM
`define WAY_NUM 2
`endif

package inst_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } IF_ID_PACKET;

    typedef struct packed {
        IF_ID_PACKET if_id_packet;
        logic        pred_taken;
        logic [31:0] pred_target;
    } INST_BUFFER_PACKET;
endpackage

interface inst_buffer_if #(
    parameter int WAY   = `WAY_NUM,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int NW    = $clog2(WAY + 1)
);
    import inst_buffer_pkg::*;

    INST_BUFFER_PACKET if_packet_i [WAY];
    logic [NW-1:0]     if_valid_num_i;
    logic [PTR_W:0]    buffer_free_o;
    logic [NW-1:0]     id_ready_num_i;
    INST_BUFFER_PACKET id_packet_o [WAY];
    logic [NW-1:0]     id_valid_num_o;

    modport slave (
        input  if_packet_i,
        input  if_valid_num_i,
        input  id_ready_num_i,
        output buffer_free_o,
        output id_packet_o,
        output id_valid_num_o
    );

    modport master (
        output if_packet_i,
        output if_valid_num_i,
        output id_ready_num_i,
        input  buffer_free_o,
        input  id_packet_o,
        input  id_valid_num_o
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular fetch-to-decode instruction queue, WAY in / WAY out per cycle.
// Optional zero-latency bypass of an empty buffer: INST_BUFFER_BYPASS_EN.
`ifndef WAY_NUM
`define WAY_NUM 2
`endif

module inst_buffer #(
    parameter int WAY   = `WAY_NUM,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    inst_buffer_if.slave bus
);
    import inst_buffer_pkg::*;

    localparam int NW = $clog2(WAY + 1);

    INST_BUFFER_PACKET entry_q [DEPTH];

    logic [PTR_W:0]   head_q, head_d;
    logic [PTR_W:0]   tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [NW-1:0]    vnum;
    logic [WAY-1:0]   we;
    logic [PTR_W-1:0] widx [WAY];

    always_comb begin : ctrl
        int cnt, nin, rdy, vo, dq, enq, byp;
        cnt = int'(count_q);
        nin = int'(bus.if_valid_num_i);
        rdy = int'(bus.id_ready_num_i);
`ifdef INST_BUFFER_BYPASS_EN
        vo = (cnt + nin < WAY) ? cnt + nin : WAY;
`else
        vo = (cnt < WAY) ? cnt : WAY;
`endif
        if (flush_i) vo = 0;
        dq  = (vo < rdy) ? vo : rdy;
        enq = (nin < DEPTH - cnt) ? nin : DEPTH - cnt;
        if (flush_i) enq = 0;
        // Slots consumed straight from fetch never touch the array.
        byp = (dq > cnt) ? dq - cnt : 0;

        vnum    = NW'(vo);
        head_d  = head_q + (PTR_W+1)'(dq - byp);
        tail_d  = tail_q + (PTR_W+1)'(enq - byp);
        count_d = count_q + (PTR_W+1)'(enq - byp)
                - (PTR_W+1)'(dq - byp);
        for (int i = 0; i < WAY; i++) begin
            we[i]   = (i >= byp) && (i < enq);
            widx[i] = tail_q[PTR_W-1:0] + PTR_W'(i - byp);
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin : outp
        bus.id_valid_num_o = vnum;
        bus.buffer_free_o  = (PTR_W+1)'(DEPTH) - count_q;
        for (int i = 0; i < WAY; i++) begin
            bus.id_packet_o[i] =
                entry_q[head_q[PTR_W-1:0] + PTR_W'(i)];
`ifdef INST_BUFFER_BYPASS_EN
            for (int j = 0; j < WAY; j++) begin
                if (i >= int'(count_q) && j == i - int'(count_q))
                    bus.id_packet_o[i] = bus.if_packet_i[j];
            end
`endif
            bus.id_packet_o[i].if_id_packet.valid = (i < int'(vnum));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < WAY; i++) begin
            if (we[i]) entry_q[widx[i]] <= bus.if_packet_i[i];
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Randomised and directed bench for inst_buffer against a queue model.
// Works with and without INST_BUFFER_BYPASS_EN.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int WAY   = 2;
    localparam int DEPTH = 8;
`ifdef INST_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    INST_BUFFER_PACKET mq[$];

    inst_buffer_if #(.WAY(WAY), .DEPTH(DEPTH)) bus();

    inst_buffer #(.WAY(WAY), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int exp_vnum();
        if (flush) return 0;
        return imin(mq.size() + (BYP ? int'(bus.if_valid_num_i) : 0), WAY);
    endfunction

    function automatic INST_BUFFER_PACKET exp_slot(input int i);
        INST_BUFFER_PACKET p;
        if (i < mq.size()) p = mq[i];
        else p = bus.if_packet_i[i - mq.size()];
        p.if_id_packet.valid = 1'b1;
        return p;
    endfunction

    task automatic drive(input int n, input logic [31:0] pc0,
                         input int rdy, input bit fl);
        INST_BUFFER_PACKET p;
        for (int i = 0; i < WAY; i++) begin
            p.if_id_packet.PC    = pc0 + 32'(4 * i);
            p.if_id_packet.NPC   = pc0 + 32'(4 * i + 4);
            p.if_id_packet.inst  = $urandom;
            p.if_id_packet.valid = (i < n);
            p.pred_taken         = 1'($urandom_range(0, 1));
            p.pred_target        = $urandom;
            bus.if_packet_i[i]   = p;
        end
        bus.if_valid_num_i = 2'(n);
        bus.id_ready_num_i = 2'(rdy);
        flush = fl;
    endtask

    // Model step: enqueue what fits, then retire what id accepted.
    task automatic tick();
        int nin, dq, enq;
        nin = int'(bus.if_valid_num_i);
        dq  = imin(exp_vnum(), int'(bus.id_ready_num_i));
        enq = imin(nin, DEPTH - mq.size());
        if (flush) mq.delete();
        else begin
            for (int i = 0; i < enq; i++) mq.push_back(bus.if_packet_i[i]);
            for (int i = 0; i < dq; i++) void'(mq.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        drive(0, 32'h0, 0, 0);
        @(negedge clock);
        #1;
        total_cnt++;
        if (bus.id_valid_num_o !== 2'd0)
            $display("FAIL rst_vnum: got %0d want 0", bus.id_valid_num_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd8)
            $display("FAIL rst_free: got %0d want 8", bus.buffer_free_o);
        else pass_cnt++;
        for (int i = 0; i < WAY; i++) begin
            total_cnt++;
            if (bus.id_packet_o[i].if_id_packet.valid !== 1'b0)
                $display("FAIL rst_valid%0d: got %b want 0", i,
                         bus.id_packet_o[i].if_id_packet.valid);
            else pass_cnt++;
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_enqueue();
        drive(2, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (int'(bus.id_valid_num_o) !== (BYP ? 2 : 0))
            $display("FAIL enq_same_cycle_vnum: got %0d want %0d",
                     bus.id_valid_num_o, BYP ? 2 : 0);
        else pass_cnt++;
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (bus.id_valid_num_o !== 2'd2)
            $display("FAIL enq_vnum: got %0d want 2", bus.id_valid_num_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.id_packet_o[0].if_id_packet.PC !== 32'h0)
            $display("FAIL enq_pc0: got %h want 0",
                     bus.id_packet_o[0].if_id_packet.PC);
        else pass_cnt++;
        total_cnt++;
        if (bus.id_packet_o[1].if_id_packet.PC !== 32'h4)
            $display("FAIL enq_pc1: got %h want 4",
                     bus.id_packet_o[1].if_id_packet.PC);
        else pass_cnt++;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd6)
            $display("FAIL enq_free: got %0d want 6", bus.buffer_free_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_fill();
        for (int g = 1; g < 4; g++) begin
            drive(2, 32'(8 * g), 0, 0);
            tick();
        end
        drive(2, 32'h20, 0, 0);
        #1;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd0)
            $display("FAIL full_free: got %0d want 0", bus.buffer_free_o);
        else pass_cnt++;
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (bus.id_packet_o[0].if_id_packet.PC !== 32'h0)
            $display("FAIL full_drop_head: got %h want 0",
                     bus.id_packet_o[0].if_id_packet.PC);
        else pass_cnt++;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd0)
            $display("FAIL full_drop_free: got %0d want 0", bus.buffer_free_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_full_traffic();
        drive(2, 32'h28, 2, 0);
        #1;
        total_cnt++;
        if (bus.id_valid_num_o !== 2'd2)
            $display("FAIL fulltr_vnum: got %0d want 2", bus.id_valid_num_o);
        else pass_cnt++;
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd2)
            $display("FAIL fulltr_free: got %0d want 2", bus.buffer_free_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.id_packet_o[0].if_id_packet.PC !== 32'h8)
            $display("FAIL fulltr_head: got %h want 8",
                     bus.id_packet_o[0].if_id_packet.PC);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        drive(0, 32'h0, 1, 0);
        tick();
        drive(2, 32'h200, 0, 1);
        #1;
        total_cnt++;
        if (bus.id_valid_num_o !== 2'd0)
            $display("FAIL flush_vnum: got %0d want 0", bus.id_valid_num_o);
        else pass_cnt++;
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (bus.buffer_free_o !== 4'd8)
            $display("FAIL flush_free: got %0d want 8", bus.buffer_free_o);
        else pass_cnt++;
        drive(2, 32'h100, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (bus.id_packet_o[0].if_id_packet.PC !== 32'h100)
            $display("FAIL flush_redirect_pc: got %h want 100",
                     bus.id_packet_o[0].if_id_packet.PC);
        else pass_cnt++;
        drive(0, 32'h0, 2, 0);
        tick();
    endtask

    task automatic test_bypass();
        drive(2, 32'h40, 1, 0);
        #1;
        total_cnt++;
        if (int'(bus.id_valid_num_o) !== (BYP ? 2 : 0))
            $display("FAIL byp_vnum: got %0d want %0d",
                     bus.id_valid_num_o, BYP ? 2 : 0);
        else pass_cnt++;
        if (exp_vnum() > 0) begin
            total_cnt++;
            if (bus.id_packet_o[0].if_id_packet.PC !== 32'h40)
                $display("FAIL byp_pc: got %h want 40",
                         bus.id_packet_o[0].if_id_packet.PC);
            else pass_cnt++;
        end
        tick();
        drive(0, 32'h0, 0, 0);
        #1;
        total_cnt++;
        if (int'(bus.buffer_free_o) !== (BYP ? 7 : 6))
            $display("FAIL byp_free: got %0d want %0d",
                     bus.buffer_free_o, BYP ? 7 : 6);
        else pass_cnt++;
        total_cnt++;
        if (bus.id_packet_o[0].if_id_packet.PC !== (BYP ? 32'h44 : 32'h40))
            $display("FAIL byp_head: got %h want %h",
                     bus.id_packet_o[0].if_id_packet.PC,
                     BYP ? 32'h44 : 32'h40);
        else pass_cnt++;
        drive(0, 32'h0, 2, 0);
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] pc, nxt;
        int n;
        pc  = 32'h1000;
        nxt = 32'h1000;
        for (int c = 0; c < 12; c++) begin
            n = imin(2, DEPTH - mq.size());
            drive(n, pc, 1, 0);
            #1;
            total_cnt++;
            if (int'(bus.id_valid_num_o) !== exp_vnum())
                $display("FAIL wrap_vnum c%0d: got %0d want %0d", c,
                         bus.id_valid_num_o, exp_vnum());
            else pass_cnt++;
            if (exp_vnum() > 0) begin
                total_cnt++;
                if (bus.id_packet_o[0].if_id_packet.PC !== nxt)
                    $display("FAIL wrap_seq c%0d: got %h want %h", c,
                             bus.id_packet_o[0].if_id_packet.PC, nxt);
                else pass_cnt++;
                nxt = nxt + 32'd4;
            end
            pc = pc + 32'(4 * n);
            tick();
        end
        drive(0, 32'h0, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(2, 32'h300, 0, 0);
        tick();
        drive(2, 32'h308, 0, 1);
        #1;
        reset = 1'b1;
        #1;
        mq.delete();
        total_cnt++;
        if (bus.buffer_free_o !== 4'd8)
            $display("FAIL midrst_free: got %0d want 8", bus.buffer_free_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.id_valid_num_o !== 2'd0)
            $display("FAIL midrst_vnum: got %0d want 0", bus.id_valid_num_o);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        drive(0, 32'h0, 0, 0);
        @(negedge clock);
    endtask

    task automatic test_random();
        INST_BUFFER_PACKET e;
        int ev;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 2), {$urandom_range(0, 65535), 2'b00},
                  $urandom_range(0, 2), $urandom_range(0, 19) == 0);
            #1;
            ev = exp_vnum();
            total_cnt++;
            if (int'(bus.id_valid_num_o) !== ev)
                $display("FAIL rnd_vnum c%0d: got %0d want %0d", c,
                         bus.id_valid_num_o, ev);
            else pass_cnt++;
            total_cnt++;
            if (int'(bus.buffer_free_o) !== DEPTH - mq.size())
                $display("FAIL rnd_free c%0d: got %0d want %0d", c,
                         bus.buffer_free_o, DEPTH - mq.size());
            else pass_cnt++;
            for (int i = 0; i < WAY; i++) begin
                total_cnt++;
                if (i < ev) begin
                    e = exp_slot(i);
                    if (bus.id_packet_o[i] !== e)
                        $display("FAIL rnd_slot%0d c%0d: got pc %h want pc %h",
                                 i, c, bus.id_packet_o[i].if_id_packet.PC,
                                 e.if_id_packet.PC);
                    else pass_cnt++;
                end else begin
                    if (bus.id_packet_o[i].if_id_packet.valid !== 1'b0)
                        $display("FAIL rnd_valid%0d c%0d: got 1 want 0", i, c);
                    else pass_cnt++;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_enqueue();
        test_fill();
        test_full_traffic();
        test_flush();
        test_bypass();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
